max7219_serial_tx: RTL and testbench
====================================

Name: max7219_serial_tx

Overview:
- Serial transmitter that drives the display chain's LOAD/DIN/CLK pins (o_serial_load, o_serial_dout, o_serial_clk) inside the digital clock.
- Accepts 16-bit MAX7219 command words (address[11:8], data[7:0]) from the display-refresh controller over a valid/ready handshake.
- Shifts each word out MSB-first with a divided SCK, then raises LOAD to latch it.
- Sits between the display controller and the top-level uio_out pins.

Parameters:
- DATA_WIDTH, 16: bits per word.
- CLK_DIV, 4: i_clk cycles per SCK half-period (D). Legal range ≥1.

Ports:
- i_clk  in  1  system clock (~10 MHz).
- i_reset  in  1  synchronous, active-high reset.
- i_en  in  1  design enable; gates acceptance only.
- i_data  in  DATA_WIDTH  word to send.
- i_valid  in  1  i_data valid.
- o_ready  out  1  block can accept a word this cycle.
- o_done  out  1  one-cycle pulse when LOAD rises (word latched).
- o_serial_dout  out  1  DIN / MOSI.
- o_serial_load  out  1  LOAD / CS; idles high.
- o_serial_clk  out  1  SCK; idles low.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is i_reset, synchronous and active-high.
- Reset values: o_serial_load=1, o_serial_clk=0, o_serial_dout=0, o_done=0, state IDLE, counters 0. o_ready=1 after reset only if i_en=1.
- States: IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP. Every non-IDLE state lasts exactly D cycles, timed by the tick counter.
- IDLE:
  - o_ready = i_en.
  - Accept occurs when i_valid & o_ready at edge t: latch i_data into the shift register, bit_cnt=DATA_WIDTH-1.
  - At t+1, enter SHIFT_LO.
- SHIFT_LO: load=0, sck=0, dout=current MSB.
- SHIFT_HI: sck=1; dout stable.
  - At end, if bit_cnt==0 go to HOLD.
  - Otherwise shift left, decrement bit_cnt, go to SHIFT_LO.
  - dout changes only on SCK falling edge or at frame start.
- HOLD: load=0, sck=0, dout=0 (LOAD setup margin).
- GAP: load=1. o_done=1 on the first GAP cycle only. Then go to IDLE.
- Timing with accept at t:
  - LOAD falls at t+1.
  - SCK rising edges at t+1+D+2kD, k=0..15.
  - LOAD rises and o_done pulses at t+33D+1.
  - o_ready returns at t+34D+1.
- o_ready=0 in every non-IDLE state; i_valid there is ignored and the word must be held by the producer.
- i_en falling mid-frame: the frame completes normally; the block then stays in IDLE with o_ready=0 until i_en=1.
- Reset mid-frame: on the next edge all outputs take their reset values and the partial word is discarded. The resulting LOAD rise may latch a garbage word; the display controller re-initialises after reset.
- CLK_DIV=1: SCK = i_clk/2. The tick counter width is $clog2(CLK_DIV) with a minimum of 1.

Optional Feature:
- Macro: SERIAL_BURST_EN.
- Defined:
  - Adds input i_last (1 bit, qualified with i_valid).
  - After a word with i_last=0, the SHIFT_HI end moves to state WAIT instead of HOLD. WAIT holds load=0, sck=0 and o_ready=i_en.
  - An accept in WAIT goes to SHIFT_LO at the next edge, with LOAD kept low.
  - A word with i_last=1 ends via HOLD/GAP with one o_done pulse.
  - This lets cascaded MAX7219s share one LOAD frame.
- Undefined: i_last is absent and every word is its own LOAD frame.

Decomposition:
- Package serial_pkg:
  - state enum.
  - MAX7219 register address constants: REG_NOOP=0x0, REG_DIGIT0..7=0x1..0x8, REG_DECODE=0x9, REG_INTENSITY=0xA, REG_SCANLIMIT=0xB, REG_SHUTDOWN=0xC, REG_TEST=0xF.
  - Default DATA_WIDTH.
- One sub-module: serial_tick_gen (down-counter, reloaded on each state entry, emits a terminal-count pulse every D cycles).

Test Plan:
- Reset: i_reset=1 for 2 cycles with i_en=1 -> load=1, sck=0, dout=0, done=0, ready=1 on the first post-reset cycle.
- Single word 0x0C01, D=4, accept at cycle 0:
  - load=0 at cycle 1.
  - 16 SCK rising edges sample 0000_1100_0000_0001.
  - load rises and done pulses at cycle 133.
  - ready at cycle 137.
- Back-to-back: i_valid held with 0x0C01 then 0x0A0F -> second accept at cycle 137, load low at 138, ready=0 throughout frame 1, exactly two done pulses.
- i_en=0 at cycle 50 of a frame -> frame bits and timing unchanged, done at 133, ready stays 0 until i_en=1 again.
- i_reset pulse at cycle 60 of a frame -> cycle 61: load=1, sck=0, dout=0. The next word 0x0F00 transmits with full correct timing.
- SERIAL_BURST_EN: 0x0101 (last=0) then 0x0202 (last=1) -> 32 SCK rising edges inside one continuous load-low window, single done pulse.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state type and MAX7219 register constants for the serial transmitter
package serial_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_HOLD,
        ST_GAP,
        ST_WAIT
    } state_t;

    localparam logic [3:0] REG_NOOP      = 4'h0;
    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DIGIT1    = 4'h2;
    localparam logic [3:0] REG_DIGIT2    = 4'h3;
    localparam logic [3:0] REG_DIGIT3    = 4'h4;
    localparam logic [3:0] REG_DIGIT4    = 4'h5;
    localparam logic [3:0] REG_DIGIT5    = 4'h6;
    localparam logic [3:0] REG_DIGIT6    = 4'h7;
    localparam logic [3:0] REG_DIGIT7    = 4'h8;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIMIT = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    function automatic logic [15:0] max7219_word(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

endpackage

// File: rtl/serial_tick_gen.sv
// rtl/serial_tick_gen.sv - down-counter that pulses o_tick on the last cycle of every CLK_DIV-cycle period
module serial_tick_gen
    import serial_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_reload,
    output logic o_tick
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLK_DIV - 1);

    logic [TW-1:0] cnt;

    assign o_tick = (cnt == '0);

    // Reloading on every state entry makes each state last exactly CLK_DIV cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (i_reload) begin
            cnt <= LAST;
        end else if (!o_tick) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/max7219_serial_tx.sv
// rtl/max7219_serial_tx.sv - MAX7219 LOAD/DIN/CLK word transmitter; SERIAL_BURST_EN shares one LOAD frame across words
module max7219_serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CLK_DIV    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
`ifdef SERIAL_BURST_EN
    input  logic                  i_last,
`endif
    output logic                  o_ready,
    output logic                  o_done,
    output logic                  o_serial_dout,
    output logic                  o_serial_load,
    output logic                  o_serial_clk
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bit_cnt;
    logic                  last_word;
    logic                  word_last;
    logic                  accept;
    logic                  tick;

`ifdef SERIAL_BURST_EN
    assign word_last = i_last;
`else
    assign word_last = 1'b1;
`endif

    assign o_ready = ((state == ST_IDLE) || (state == ST_WAIT)) && i_en;
    assign accept  = i_valid && o_ready;

    serial_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_reload (accept || tick),
        .o_tick   (tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            last_word     <= 1'b1;
            o_serial_load <= 1'b1;
            o_serial_clk  <= 1'b0;
            o_serial_dout <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE, ST_WAIT: begin
                    if (accept) begin
                        shreg         <= i_data;
                        bit_cnt       <= BW'(DATA_WIDTH - 1);
                        last_word     <= word_last;
                        state         <= ST_SHIFT_LO;
                        o_serial_load <= 1'b0;
                        o_serial_clk  <= 1'b0;
                        o_serial_dout <= i_data[DATA_WIDTH-1];
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick) begin
                        state        <= ST_SHIFT_HI;
                        o_serial_clk <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick) begin
                        o_serial_clk <= 1'b0;
                        if (bit_cnt == '0) begin
                            o_serial_dout <= 1'b0;
                            state         <= last_word ? ST_HOLD : ST_WAIT;
                        end else begin
                            // DIN moves together with the SCK falling edge
                            shreg         <= shreg << 1;
                            bit_cnt       <= bit_cnt - 1'b1;
                            o_serial_dout <= shreg[DATA_WIDTH-2];
                            state         <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        state         <= ST_GAP;
                        o_serial_load <= 1'b1;
                        o_done        <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_max7219_serial_tx.sv
// tb/tb_max7219_serial_tx.sv - randomized self-checking bench for max7219_serial_tx (SERIAL_BURST_EN optional)
module tb_max7219_serial_tx;

    localparam int D     = 4;
    localparam int DW    = 16;
    localparam int FRAME = 34 * D;

    logic          clk     = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_en    = 1'b1;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data  = '0;
`ifdef SERIAL_BURST_EN
    logic          i_last  = 1'b1;
`endif
    logic o_ready, o_done, o_serial_dout, o_serial_load, o_serial_clk;

    int   cyc         = 0;
    logic rst_at_edge = 1'b1;
    logic acc_at_edge = 1'b0;
    logic p_sck = 1'b0, p_dout = 1'b0, p_load = 1'b1, p_rdy = 1'b0;
    int   dout_viol = 0;
    int   rise_t[$];
    logic rise_b[$];
    int   lfall[$], lrise[$], done_t[$], rdy_rise[$];
    int   n_assert = 0, n_fail = 0;

    always #50 clk = ~clk;

    max7219_serial_tx #(
        .DATA_WIDTH (DW),
        .CLK_DIV    (D)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_en          (i_en),
        .i_data        (i_data),
        .i_valid       (i_valid),
`ifdef SERIAL_BURST_EN
        .i_last        (i_last),
`endif
        .o_ready       (o_ready),
        .o_done        (o_done),
        .o_serial_dout (o_serial_dout),
        .o_serial_load (o_serial_load),
        .o_serial_clk  (o_serial_clk)
    );

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= i_reset;
        acc_at_edge <= i_valid & o_ready;
    end

    // Event recorder: cycle stamps of pin transitions as seen between edges.
    always @(negedge clk) begin
        if (!rst_at_edge) begin
            if (o_serial_clk && !p_sck) begin
                rise_t.push_back(cyc);
                rise_b.push_back(o_serial_dout);
            end
            if (!o_serial_load && p_load) lfall.push_back(cyc);
            if (o_serial_load && !p_load) lrise.push_back(cyc);
            if (o_done) done_t.push_back(cyc);
            if (o_ready && !p_rdy) rdy_rise.push_back(cyc);
            if (o_serial_dout !== p_dout && !(p_sck && !o_serial_clk) && !acc_at_edge)
                dout_viol <= dout_viol + 1;
        end
        p_sck  <= o_serial_clk;
        p_dout <= o_serial_dout;
        p_load <= o_serial_load;
        p_rdy  <= o_ready;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_q();
        rise_t.delete();
        rise_b.delete();
        lfall.delete();
        lrise.delete();
        done_t.delete();
        rdy_rise.delete();
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at a negedge; returns the index of the edge that accepts the word.
    task automatic send(input logic [DW-1:0] w, output int a);
        int n = 0;
        i_data  = w;
        i_valid = 1'b1;
        while (!o_ready && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", int'(o_ready), 1);
        a = cyc + 1;
        @(negedge clk);
    endtask

    // Word f of the recorded SCK stream must carry w MSB-first, rising at a+D+2kD.
    task automatic chk_bits(input string tag, input logic [DW-1:0] w, input int a, input int f);
        logic [DW-1:0] got   = '0;
        int            bad_t = 0;
        for (int k = 0; k < DW; k++) begin
            if (f * DW + k < rise_t.size()) begin
                got[DW-1-k] = rise_b[f*DW+k];
                if (rise_t[f*DW+k] != a + D + 2 * k * D) bad_t++;
            end else begin
                bad_t++;
            end
        end
        check({tag, "_bits"}, int'(got), int'(w));
        check({tag, "_sck_timing"}, bad_t, 0);
    endtask

    task automatic chk_frame(input string tag, input logic [DW-1:0] w, input int a, input int f,
                             input bit chk_rdy);
        chk_bits(tag, w, a, f);
        check({tag, "_load_fall"}, qget(lfall, f), a);
        check({tag, "_load_rise"}, qget(lrise, f), a + 33 * D);
        check({tag, "_done"}, qget(done_t, f), a + 33 * D);
        if (chk_rdy) check({tag, "_ready_return"}, qget(rdy_rise, f), a + FRAME);
    endtask

    initial begin
        int            a;
        int            a2;
        logic [DW-1:0] w;

        repeat (2) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        check("reset_load", int'(o_serial_load), 1);
        check("reset_sck", int'(o_serial_clk), 0);
        check("reset_dout", int'(o_serial_dout), 0);
        check("reset_done", int'(o_done), 0);
        check("reset_ready", int'(o_ready), 1);
        @(negedge clk);

        clear_q();
        send(16'h0C01, a);
        i_valid = 1'b0;
        wait_until(a + FRAME + 1);
        check("single_sck_count", rise_t.size(), DW);
        chk_frame("single", 16'h0C01, a, 0, 1'b1);

        clear_q();
        send(16'h0C01, a);
        send(16'h0A0F, a2);
        i_valid = 1'b0;
        check("b2b_second_accept", a2, a + FRAME + 1);
        wait_until(a2 + FRAME + 1);
        check("b2b_done_count", done_t.size(), 2);
        chk_frame("b2b0", 16'h0C01, a, 0, 1'b1);
        chk_frame("b2b1", 16'h0A0F, a2, 1, 1'b1);

        for (int r = 0; r < 4; r++) begin
            w = DW'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            clear_q();
            send(w, a);
            i_valid = 1'b0;
            wait_until(a + FRAME + 1);
            chk_frame($sformatf("rand%0d", r), w, a, 0, 1'b1);
        end

        clear_q();
        w = DW'($urandom);
        send(w, a);
        i_valid = 1'b0;
        wait_until(a + 50);
        i_en = 1'b0;
        wait_until(a + FRAME + 6);
        chk_frame("en_drop", w, a, 0, 1'b0);
        check("en_drop_ready_low", int'(o_ready), 0);
        check("en_drop_no_ready", rdy_rise.size(), 0);
        i_en = 1'b1;
        @(negedge clk);
        check("en_restore_ready", int'(o_ready), 1);

        clear_q();
        send(DW'($urandom), a);
        i_valid = 1'b0;
        wait_until(a + 59);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        check("rst_mid_load", int'(o_serial_load), 1);
        check("rst_mid_sck", int'(o_serial_clk), 0);
        check("rst_mid_dout", int'(o_serial_dout), 0);
        @(negedge clk);
        clear_q();
        send(16'h0F00, a);
        i_valid = 1'b0;
        wait_until(a + FRAME + 1);
        check("after_rst_sck_count", rise_t.size(), DW);
        chk_frame("after_rst", 16'h0F00, a, 0, 1'b1);

`ifdef SERIAL_BURST_EN
        clear_q();
        i_last = 1'b0;
        send(16'h0101, a);
        i_last = 1'b1;
        send(16'h0202, a2);
        i_valid = 1'b0;
        check("burst_second_accept", a2, a + 32 * D + 1);
        wait_until(a2 + FRAME + 1);
        check("burst_sck_count", rise_t.size(), 2 * DW);
        chk_bits("burst0", 16'h0101, a, 0);
        chk_bits("burst1", 16'h0202, a2, 1);
        check("burst_load_falls", lfall.size(), 1);
        check("burst_load_fall", qget(lfall, 0), a);
        check("burst_load_rises", lrise.size(), 1);
        check("burst_load_rise", qget(lrise, 0), a2 + 33 * D);
        check("burst_done_count", done_t.size(), 1);
        check("burst_done", qget(done_t, 0), a2 + 33 * D);
`endif

        check("dout_only_at_sck_fall", dout_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
